pc_unit: RTL

Parametrised fetch-stage program counter for the pipelined MIPS core. It holds the PC of the instruction being fetched and selects the next PC from sequential, branch, jump and jump-register targets, the exception entry vector and the eret return address (EPC). It also reports misaligned or out-of-range fetch addresses (AdEL) and counts accepted fetches. It sits in F and drives instruction memory and the F/D pipeline register.

---
 rtl/pc_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter.
// Holds the PC being fetched, selects the next PC from sequential, branch,
// jump, jump-register, exception-vector and eret sources, flags fetch
// address errors (AdEL) and counts accepted normal fetch updates.
module pc_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_PC   = 32'h0000_4180,
  parameter logic [WIDTH-1:0] IM_BASE  = 32'h0000_3000,
  parameter logic [WIDTH-1:0] IM_LIMIT = 32'h0000_6FFC,
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_en,
  input  logic [2:0]       npc_op,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic [WIDTH-1:0] j_target,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc_F,
  output logic [WIDTH-1:0] pc4_F,
  output logic             adel_F,
  output logic             redir_F,
  output logic [CNT_W-1:0] fetch_cnt
);

  // Next-PC select encodings driven by the decode stage; 4..7 are reserved
  // and fall back to the sequential address.
  localparam logic [2:0] NPC_SEQ    = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;

  localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'b100};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // A fetch address is bad when it is not word aligned or lies outside the
  // instruction memory window; targets are never realigned, only flagged.
  function automatic logic fetch_addr_err(input logic [WIDTH-1:0] addr);
    logic misaligned;
    logic below;
    logic above;
    misaligned = (addr[1:0] != 2'b00);
    below      = (addr < IM_BASE);
    above      = (addr > IM_LIMIT);
    return misaligned | below | above;
  endfunction

  // Sequential-path next PC for a normal update, by select code.
  function automatic logic [WIDTH-1:0] normal_npc(
    input logic [2:0]       op,
    input logic             taken,
    input logic [WIDTH-1:0] seq_pc,
    input logic [WIDTH-1:0] br_pc,
    input logic [WIDTH-1:0] j_pc,
    input logic [WIDTH-1:0] jr_pc
  );
    logic [WIDTH-1:0] result;
    case (op)
      NPC_SEQ:    result = seq_pc;
      NPC_BRANCH: result = taken ? br_pc : seq_pc;
      NPC_JUMP:   result = j_pc;
      NPC_JR:     result = jr_pc;
      default:    result = seq_pc;
    endcase
    return result;
  endfunction

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             redir_q;
  logic             redir_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] pc4_s;

  assign pc4_s = pc_q + PC_STEP;

  // Next-state selection: exception > eret > normal update > hold.
  always_comb begin
    pc_d    = pc_q;
    redir_d = redir_q;
    cnt_d   = cnt_q;
    if (exc_req) begin
      pc_d    = EXC_PC;
      redir_d = 1'b1;
    end else if (eret_req) begin
      pc_d    = epc;
      redir_d = 1'b1;
    end else if (pc_en) begin
      pc_d    = normal_npc(npc_op, branch_taken, pc4_s,
                           br_target, j_target, jr_target);
      redir_d = 1'b0;
      cnt_d   = cnt_q + CNT_ONE;
    end else begin
      pc_d    = pc_q;
      redir_d = redir_q;
      cnt_d   = cnt_q;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      redir_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      pc_q    <= pc_d;
      redir_q <= redir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_F      = pc_q;
  assign pc4_F     = pc4_s;
  assign adel_F    = fetch_addr_err(pc_q);
  assign redir_F   = redir_q;
  assign fetch_cnt = cnt_q;

endmodule
